// File: rtl/psk_pkg.sv
// psk_pkg: shared state encoding, mode constants and default sync word for the PSK frame synchroniser
package psk_pkg;
    typedef enum logic {
        SEARCH  = 1'b0,
        PAYLOAD = 1'b1
    } state_t;
    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;
    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACFFC1D;
endpackage

// File: rtl/popcount32.sv
// popcount32: combinational Hamming weight of a 32-bit word
module popcount32 (
    input  logic [31:0] x,
    output logic [5:0]  cnt
);
    // ripple-add every bit; small enough to stay a plain adder tree after synthesis
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 32; i++) cnt = cnt + {5'd0, x[i]};
    end
endmodule

// File: rtl/psk_frame_sync.sv
// psk_frame_sync: serialises PSK hard decisions, finds the sync word and packs the payload into bytes
module psk_frame_sync
    import psk_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
    parameter int          PAYLOAD_BYTES = 64,
    parameter int          MAX_ERR       = 2
) (
    input  logic       clk,
    input  logic       rst_32M768_n,
    input  logic       clk_enable,
    input  logic       mode,
    input  logic       BPSK,
    input  logic [1:0] QPSK,
    input  logic       vld,
    output logic [7:0] byte_tdata,
    output logic       byte_tvalid,
    input  logic       byte_tready,
    output logic       byte_tlast,
    output logic       frame_lock,
    output logic       frame_start,
    output logic       inverted,
    output logic       overflow
);
    localparam logic [5:0] MAX_E    = 6'(MAX_ERR);
    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

    state_t      state, state_d;
    logic [31:0] sr, sr_d, sr_sh;
    logic [5:0]  fill, fill_d, fill_sum, dist_n, dist_i;
    logic [7:0]  pack, pack_d, byte_cnt, byte_cnt_d, tdata_d;
    logic [2:0]  bit_cnt, bit_cnt_d;
    logic [3:0]  cnt_sum;
    logic [1:0]  dbits;
    logic        mode_q, mode_q_d, eff_mode, acc, xfer, hit_n, hit_i, last;
    logic        tvalid_d, tlast_d, inverted_d, frame_start_d, overflow_d;

    popcount32 u_pc_norm (.x(sr_sh ^ SYNC_WORD),  .cnt(dist_n));
    popcount32 u_pc_inv  (.x(sr_sh ^ ~SYNC_WORD), .cnt(dist_i));

    assign frame_lock = (state == PAYLOAD);
    assign acc        = clk_enable && vld;
    assign xfer       = clk_enable && byte_tvalid && byte_tready;

    // fill counts bits seen since search (re)started so that no match fires on a partly filled register
    always_comb begin
        eff_mode = (state == SEARCH) ? mode : mode_q;
        sr_sh    = eff_mode ? {sr[29:0], QPSK} : {sr[30:0], BPSK};
        dbits    = (eff_mode ? QPSK : {1'b0, BPSK}) ^ {2{inverted}};
        cnt_sum  = {1'b0, bit_cnt} + (eff_mode ? 4'd2 : 4'd1);
        fill_sum = fill + (eff_mode ? 6'd2 : 6'd1);
        hit_n    = fill_sum >= 6'd32 && dist_n <= MAX_E;
        hit_i    = fill_sum >= 6'd32 && dist_i <= MAX_E;
        last     = byte_cnt == LAST_IDX;
    end

    // next-state logic: search/lock, byte packing, holding-register handshake and frame end
    always_comb begin
        state_d       = state;
        sr_d          = sr;
        fill_d        = fill;
        pack_d        = pack;
        bit_cnt_d     = bit_cnt;
        byte_cnt_d    = byte_cnt;
        mode_q_d      = mode_q;
        inverted_d    = inverted;
        frame_start_d = 1'b0;
        tdata_d       = byte_tdata;
        tvalid_d      = byte_tvalid && !xfer;
        tlast_d       = byte_tlast;
        overflow_d    = overflow;
        if (acc && state == SEARCH) begin
            sr_d   = sr_sh;
            fill_d = (fill_sum > 6'd32) ? 6'd32 : fill_sum;
            if (hit_n || hit_i) begin
                state_d       = PAYLOAD;
                inverted_d    = !hit_n;
                mode_q_d      = mode;
                frame_start_d = 1'b1;
            end
        end else if (acc) begin
            pack_d    = eff_mode ? {pack[5:0], dbits} : {pack[6:0], dbits[0]};
            bit_cnt_d = cnt_sum[2:0];
            if (cnt_sum[3]) begin
                byte_cnt_d = byte_cnt + 8'd1;
                if (!byte_tvalid || xfer) begin
                    tdata_d  = pack_d;
                    tvalid_d = 1'b1;
                    tlast_d  = last;
                end else begin
                    overflow_d = 1'b1;
                end
                if (last) begin
                    state_d    = SEARCH;
                    sr_d       = '0;
                    fill_d     = '0;
                    pack_d     = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
        end
    end

    // state and output registers; clk_enable low freezes everything
    always_ff @(posedge clk or negedge rst_32M768_n) begin
        if (!rst_32M768_n) begin
            state       <= SEARCH;
            sr          <= '0;
            fill        <= '0;
            pack        <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            mode_q      <= MODE_BPSK;
            inverted    <= 1'b0;
            frame_start <= 1'b0;
            byte_tdata  <= '0;
            byte_tvalid <= 1'b0;
            byte_tlast  <= 1'b0;
            overflow    <= 1'b0;
        end else if (clk_enable) begin
            state       <= state_d;
            sr          <= sr_d;
            fill        <= fill_d;
            pack        <= pack_d;
            bit_cnt     <= bit_cnt_d;
            byte_cnt    <= byte_cnt_d;
            mode_q      <= mode_q_d;
            inverted    <= inverted_d;
            frame_start <= frame_start_d;
            byte_tdata  <= tdata_d;
            byte_tvalid <= tvalid_d;
            byte_tlast  <= tlast_d;
            overflow    <= overflow_d;
        end
    end
endmodule

// File: tb/tb_psk_frame_sync.sv
// tb_psk_frame_sync: directed table-driven bench for psk_frame_sync
module tb_psk_frame_sync;
    import psk_pkg::*;
    localparam logic [31:0] SW = DEFAULT_SYNC_WORD;

    logic       clk, rst_n, clk_enable, mode, BPSK, vld, byte_tready;
    logic [1:0] QPSK;
    logic [7:0] byte_tdata;
    logic       byte_tvalid, byte_tlast, frame_lock, frame_start, inverted, overflow;

    int total = 0;
    int bad = 0;
    logic gaps, toggle;
    logic [7:0] rx_d[$];
    logic       rx_l[$];
    logic [7:0] exp_d[$];

    typedef struct {
        logic        m;
        logic        inv;
        logic [31:0] flips;
        int          pat;
        logic        lock;
        logic        exp_inv;
    } vec_t;
    vec_t tbl[6];

    psk_frame_sync dut (
        .clk(clk), .rst_32M768_n(rst_n), .clk_enable(clk_enable), .mode(mode),
        .BPSK(BPSK), .QPSK(QPSK), .vld(vld),
        .byte_tdata(byte_tdata), .byte_tvalid(byte_tvalid), .byte_tready(byte_tready),
        .byte_tlast(byte_tlast), .frame_lock(frame_lock), .frame_start(frame_start),
        .inverted(inverted), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && clk_enable && byte_tvalid && byte_tready) begin
            rx_d.push_back(byte_tdata);
            rx_l.push_back(byte_tlast);
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sym(input logic m, input logic [1:0] d);
        if (gaps && $urandom_range(0, 3) == 0) begin
            clk_enable = 1'b0;
            vld = 1'b1;
            BPSK = 1'($urandom);
            QPSK = 2'($urandom);
            @(posedge clk); #1;
        end
        clk_enable = 1'b1;
        vld = 1'b1;
        mode = toggle ? ~mode : m;
        BPSK = m ? 1'($urandom) : d[0];
        QPSK = m ? d : 2'($urandom);
        @(posedge clk); #1;
        vld = 1'b0;
    endtask

    task automatic send_sync(input logic m, input logic inv, input logic [31:0] flips);
        logic [31:0] w;
        w = SW ^ flips ^ {32{inv}};
        if (m) for (int k = 0; k < 16; k++) sym(1'b1, w[31-2*k -: 2]);
        else   for (int k = 0; k < 32; k++) sym(1'b0, {1'b0, w[31-k]});
    endtask

    task automatic send_byte(input logic m, input logic inv, input logic [7:0] b);
        logic [7:0] x;
        x = b ^ {8{inv}};
        if (m) for (int k = 0; k < 4; k++) sym(1'b1, x[7-2*k -: 2]);
        else   for (int k = 0; k < 8; k++) sym(1'b0, {1'b0, x[7-k]});
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        clk_enable = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_rx(input string tag);
        int errs = 0;
        int nl = 0;
        int lp = -1;
        chk({tag, " count"}, 32'(rx_d.size()), 32'(exp_d.size()));
        foreach (rx_d[i]) begin
            if (i < exp_d.size() && rx_d[i] !== exp_d[i]) errs++;
            if (rx_l[i]) begin nl++; lp = i; end
        end
        chk({tag, " data errors"}, 32'(errs), 32'd0);
        chk({tag, " tlast count"}, 32'(nl), 32'd1);
        chk({tag, " tlast pos"}, 32'(lp), 32'(exp_d.size() - 1));
        rx_d.delete();
        rx_l.delete();
        exp_d.delete();
    endtask

    function automatic logic [31:0] outs();
        return {17'd0, byte_tdata, byte_tvalid, byte_tlast, frame_lock, frame_start, inverted, overflow, 1'b0};
    endfunction

    initial begin
        logic [7:0] b;
        rst_n = 1'b0; clk_enable = 1'b1; vld = 1'b0; mode = 1'b0;
        BPSK = 1'b0; QPSK = 2'b00; byte_tready = 1'b1; gaps = 1'b0; toggle = 1'b0;
        tbl[0] = '{1'b0, 1'b0, 32'h80010001, 2, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 32'h00000000, 0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h00000000, 0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 32'h80000001, 0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h00000000, 1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h00000100, 0, 1'b1, 1'b1};
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", outs(), 32'd0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            send_sync(tbl[i].m, tbl[i].inv, tbl[i].flips);
            chk($sformatf("v%0d frame_start", i), 32'(frame_start), 32'(tbl[i].lock));
            chk($sformatf("v%0d frame_lock", i), 32'(frame_lock), 32'(tbl[i].lock));
            chk($sformatf("v%0d inverted", i), 32'(inverted), 32'(tbl[i].exp_inv));
            toggle = tbl[i].lock;
            for (int k = 0; k < 64; k++) begin
                b = (tbl[i].pat == 0) ? 8'(k) : (tbl[i].pat == 1) ? 8'hA5 : 8'h00;
                send_byte(tbl[i].m, tbl[i].inv, b);
                if (tbl[i].lock) exp_d.push_back(b);
            end
            toggle = 1'b0;
            mode = tbl[i].m;
            idle(6);
            if (tbl[i].lock) check_rx($sformatf("v%0d", i));
            else begin
                chk($sformatf("v%0d no bytes", i), 32'(rx_d.size()), 32'd0);
                chk($sformatf("v%0d outputs idle", i), outs(), 32'd0);
            end
            chk($sformatf("v%0d lock dropped", i), 32'(frame_lock), 32'd0);
        end
        chk("no overflow yet", 32'(overflow), 32'd0);

        send_sync(1'b1, 1'b0, 32'd0);
        chk("stall lock", 32'(frame_lock), 32'd1);
        byte_tready = 1'b0;
        send_byte(1'b1, 1'b0, 8'h80);
        chk("stall first valid", 32'(byte_tvalid), 32'd1);
        chk("stall first data", 32'(byte_tdata), 32'h80);
        send_byte(1'b1, 1'b0, 8'h81);
        chk("stall overflow", 32'(overflow), 32'd1);
        chk("stall data held", 32'(byte_tdata), 32'h80);
        b = 8'h82;
        sym(1'b1, b[7:6]);
        sym(1'b1, b[5:4]);
        chk("stall data still held", {byte_tvalid, byte_tlast, byte_tdata}, 32'h280);
        byte_tready = 1'b1;
        sym(1'b1, b[3:2]);
        sym(1'b1, b[1:0]);
        for (int k = 3; k < 64; k++) send_byte(1'b1, 1'b0, 8'h80 + 8'(k));
        idle(6);
        exp_d.push_back(8'h80);
        for (int k = 2; k < 64; k++) exp_d.push_back(8'h80 + 8'(k));
        check_rx("stall");
        chk("overflow sticky", 32'(overflow), 32'd1);

        send_sync(1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) send_byte(1'b0, 1'b0, 8'h55);
        chk("pre-reset lock", 32'(frame_lock), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", outs(), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_d.delete();
        rx_l.delete();
        gaps = 1'b1;
        send_sync(1'b0, 1'b0, 32'd0);
        chk("post-reset frame_start", 32'(frame_start), 32'd1);
        toggle = 1'b1;
        for (int k = 0; k < 64; k++) begin
            send_byte(1'b0, 1'b0, 8'(k) ^ 8'hC3);
            exp_d.push_back(8'(k) ^ 8'hC3);
        end
        toggle = 1'b0;
        gaps = 1'b0;
        mode = 1'b0;
        idle(6);
        check_rx("post-reset");
        chk("post-reset flags", {30'd0, overflow, inverted}, 32'd0);
        chk("post-reset unlocked", 32'(frame_lock), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/psk_frame_sync.md
Name: psk_frame_sync

Overview:
- Sits directly downstream of the PSK hard-decision stage.
- Consumes the per-symbol BPSK/QPSK sign decisions and serialises them into a bit stream.
- Searches for a 32-bit sync word, tolerating bit errors and 180° phase inversion.
- After lock, packs the fixed-length payload into bytes on a valid/ready stream, then returns to search.

Parameters:
- SYNC_WORD, 32'h1ACFFC1D, sync pattern, MSB received first
- PAYLOAD_BYTES, 64, bytes emitted per frame after sync (range 1..255)
- MAX_ERR, 2, max Hamming distance accepted as sync match (range 0..7)

Ports:
- clk  in  1  32.768 MHz system clock
- rst_32M768_n  in  1  asynchronous active-low reset
- clk_enable  in  1  global clock enable; no state changes when low
- mode  in  1  0 = BPSK, 1 = QPSK; sampled only in SEARCH
- BPSK  in  1  BPSK hard decision (sign bit)
- QPSK  in  2  QPSK hard decision, [1] = I sign, [0] = Q sign
- vld  in  1  decision valid
- byte_tdata  out  8  payload byte, first-received bit in MSB
- byte_tvalid  out  1  byte available
- byte_tready  in  1  downstream accepts byte
- byte_tlast  out  1  marks the last byte of a frame
- frame_lock  out  1  high while in PAYLOAD state
- frame_start  out  1  one-cycle pulse on sync detection
- inverted  out  1  locked on the inverted sync word (180° ambiguity)
- overflow  out  1  sticky: a byte was dropped

Behaviour:
- Reset (async, rst_32M768_n low): every output is 0; shift register, counters and holding register are cleared; state = SEARCH. Reset mid-frame abandons the frame with no tlast.
- Accepted symbol: a clk edge with clk_enable && vld.
  - BPSK mode shifts in 1 bit (BPSK).
  - QPSK mode shifts in 2 bits, QPSK[1] then QPSK[0].
- mode is latched into mode_q at lock and held for the whole frame; mode changes in PAYLOAD are ignored.
- SEARCH:
  - On each accepted symbol, compute the Hamming distance of the next-value 32-bit shift register against SYNC_WORD and against ~SYNC_WORD.
  - If dist(SYNC_WORD) <= MAX_ERR: go to PAYLOAD with inverted = 0.
  - Else if dist(~SYNC_WORD) <= MAX_ERR: go to PAYLOAD with inverted = 1. The normal match has priority.
  - frame_lock rises and frame_start pulses on the edge that accepts the completing symbol, i.e. both are registered and visible the following cycle.
  - In QPSK mode the sync word is only detected symbol-aligned.
- PAYLOAD:
  - Bits are XORed with inverted and accumulated MSB-first into an 8-bit packer: 8 symbols per byte in BPSK, 4 in QPSK.
  - On the accepted symbol that completes a byte, the byte loads into the holding register and byte_tvalid = 1 the next cycle.
- Output handshake:
  - Transfer occurs on an edge with clk_enable && byte_tvalid && byte_tready.
  - byte_tdata and byte_tlast are stable while byte_tvalid && !byte_tready.
  - If a byte completes while the holding register is full and no transfer happens on the same edge, the new byte is dropped and overflow sets.
  - If a transfer does happen on that same edge, the new byte replaces the old one with no loss.
  - Dropped bytes still count toward PAYLOAD_BYTES.
- Frame end:
  - The byte that brings the byte counter to PAYLOAD_BYTES carries byte_tlast = 1.
  - On that edge: state returns to SEARCH, frame_lock falls, and the shift register and packer clear.
  - A pending tlast byte still drains through the holding register after frame_lock falls.
  - Search restarts with the next accepted symbol; no sync can be detected earlier than 32 bits later.
- Flags:
  - overflow clears only on reset.
  - inverted holds its value until the next lock.
- clk_enable low freezes everything, including handshake evaluation.

Decomposition:
- Shared package psk_pkg: state encoding (SEARCH = 1'b0, PAYLOAD = 1'b1), MODE_BPSK/MODE_QPSK constants, default SYNC_WORD.
- One sub-module: popcount32, a combinational 32-bit Hamming weight producing 6 bits. It is instantiated twice (normal and inverted XOR).

Test Plan:
- BPSK, tready = 1: 32 sync bits then bytes 0x00..0x3F → frame_start one cycle after the 32nd symbol; 64 bytes out in order; tlast on 0x3F; frame_lock low afterwards.
- BPSK stream with all bits inverted (~SYNC_WORD, ~payload) → inverted = 1; payload restored, first byte 0x00.
- Sync word with 2 flipped bits → locks. With 3 flipped bits (MAX_ERR = 2) → no frame_start; all outputs stay 0.
- QPSK, 16 symbols carrying SYNC_WORD then payload 0xA5 repeated → byte_tvalid every 4 accepted symbols, data 0xA5; mode toggled mid-frame has no effect.
- QPSK back-to-back symbols with byte_tready = 0 for 10 symbols → first byte held stable, overflow = 1, dropped byte counted, tlast still on the 64th byte position.
- Assert rst_32M768_n low mid-payload for one cycle → all outputs 0 asynchronously. A subsequent clean frame is received correctly; clk_enable = 0 periods inserted change nothing.
